// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared fetch/decode constants and state encoding
package instruction_fetch_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;
    localparam int INSTR_WIDTH = 16;
    localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;
    localparam int OPCODE_WIDTH = 4;
    function automatic logic [OPCODE_WIDTH-1:0] opcode_of(input logic [INSTR_WIDTH-1:0] w);
        return w[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    endfunction
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: memory port, decoder handshake and redirect bundle
interface instruction_fetch_if
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_rd_en;
    logic [INSTR_WIDTH-1:0] mem_rdata;
    logic [INSTR_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic [ADDR_WIDTH-1:0]  instr_pc_plus1;
    logic                   instr_valid;
    logic                   instr_ready;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;
    modport master (
        output mem_addr, mem_rd_en, instr, instr_pc, instr_pc_plus1, instr_valid,
        input  mem_rdata, instr_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  mem_addr, mem_rd_en, instr, instr_pc, instr_pc_plus1, instr_valid,
        output mem_rdata, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing 1-cycle-latency reads and holding words for decode
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input logic                 clk,
    input logic                 reset,
    instruction_fetch_if.master bus
);
    fetch_state_t state, state_nxt;
    logic [ADDR_WIDTH-1:0]  pc;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [ADDR_WIDTH-1:0]  instr_pc_q;
    logic [ADDR_WIDTH-1:0]  instr_pc_plus1_q;
    logic                   instr_valid_q;

    // state register; reset parks in IDLE so no read is issued right after release
    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_nxt;
    end

    // next state; a redirect always restarts with a fresh fetch
    always_comb begin
        state_nxt = bus.redirect_valid ? FETCH :
                    state == IDLE      ? FETCH :
                    state == FETCH     ? WAIT  :
                    state == WAIT      ? HOLD  :
                    bus.instr_ready    ? FETCH : HOLD;
    end

    // PC and held instruction; redirect squashes both in-flight data and a held word
    always_ff @(posedge clk) begin
        if (reset) begin
            pc               <= RESET_PC;
            instr_q          <= '0;
            instr_pc_q       <= '0;
            instr_pc_plus1_q <= '0;
            instr_valid_q    <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc            <= bus.redirect_pc;
            instr_valid_q <= 1'b0;
        end else if (state == WAIT) begin
            instr_q          <= bus.mem_rdata;
            instr_pc_q       <= pc;
            instr_pc_plus1_q <= pc + 1'b1;
            pc               <= pc + 1'b1;
            instr_valid_q    <= 1'b1;
        end else if (state == HOLD && bus.instr_ready) begin
            instr_valid_q <= 1'b0;
        end
    end

    // outputs; the memory address always tracks the PC, the strobe gates its use
    always_comb begin
        bus.mem_addr       = pc;
        bus.mem_rd_en      = state == FETCH;
        bus.instr          = instr_q;
        bus.instr_pc       = instr_pc_q;
        bus.instr_pc_plus1 = instr_pc_plus1_q;
        bus.instr_valid    = instr_valid_q;
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: randomized and directed checks against a transaction-level fetch model
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] mem [0:65535];
    int n_checks = 0;
    int n_pass = 0;
    bit armed = 1'b0;
    int left = 0;
    logic [15:0] exp_pc = 16'h0;

    instruction_fetch_if #(.ADDR_WIDTH(16)) bus ();

    instruction_fetch #(.ADDR_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // synchronous-read instruction memory
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // one clock: drive inputs, compare at negedge, then advance the model across the edge
    task automatic step(input logic r, input logic rv, input logic [15:0] rpc, input logic rdy);
        logic [15:0] nxt;
        reset = r;
        bus.redirect_valid = rv;
        bus.redirect_pc = rpc;
        bus.instr_ready = rdy;
        @(negedge clk);
        if (armed) begin
            if (left > 0) begin
                check("valid_low", 32'(bus.instr_valid), 32'd0);
                check("rd_en", 32'(bus.mem_rd_en), 32'(left == 2));
                check("mem_addr", 32'(bus.mem_addr), 32'(exp_pc));
            end else begin
                nxt = exp_pc + 16'd1;
                check("valid_high", 32'(bus.instr_valid), 32'd1);
                check("rd_en_hold", 32'(bus.mem_rd_en), 32'd0);
                check("instr", 32'(bus.instr), 32'(mem[exp_pc]));
                check("instr_pc", 32'(bus.instr_pc), 32'(exp_pc));
                check("pc_plus1", 32'(bus.instr_pc_plus1), 32'(nxt));
                check("mem_addr_hold", 32'(bus.mem_addr), 32'(nxt));
            end
        end
        if (r) begin
            armed = 1'b1;
            exp_pc = 16'h0000;
            left = 3;
        end else if (rv) begin
            exp_pc = rpc;
            left = 2;
        end else if (left > 0) begin
            left--;
        end else if (rdy) begin
            exp_pc = exp_pc + 16'd1;
            left = 2;
        end
        @(posedge clk);
        #1;
    endtask

    // run with ready high until the model reaches the wanted phase, bounded
    task automatic go_to(input int want);
        for (int i = 0; i < 10 && left != want; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        check("sync", 32'(left), 32'(want));
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[0] = 16'h5103;
        mem[16'hFFFF] = 16'h0000;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0;
        bus.instr_ready = 1'b1;
        step(1'b1, 1'b0, 16'h0, 1'b1);
        step(1'b1, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        go_to(0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
        step(1'b0, 1'b0, 16'h0, 1'b1);
        go_to(1);
        step(1'b0, 1'b1, 16'h0040, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        go_to(0);
        step(1'b0, 1'b1, 16'h1234, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        step(1'b0, 1'b1, 16'hFFFF, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        go_to(1);
        step(1'b1, 1'b1, 16'h0777, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 16'h0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] rpc;
            rpc = ($urandom_range(0, 3) == 0) ? 16'hFFFF - 16'($urandom_range(0, 3)) : 16'($urandom);
            step($urandom_range(0, 63) == 0, $urandom_range(0, 9) == 0, rpc, 1'($urandom_range(0, 1)));
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Upstream neighbour of the instruction decode stage. Owns the program counter and issues word reads to a synchronous-read instruction memory with 1-cycle read latency. Captures each returned 16-bit word and presents it, with its address and PC+1, to the decoder over a valid/ready handshake. Accepts redirects (branch, jump, JAL target) from the execute/control stage.

Parameters:
ADDR_WIDTH, 16, width of PC and memory word address (word-addressed).
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  single system clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
mem_addr  out  ADDR_WIDTH  instruction memory word address, driven from the PC register.
mem_rd_en  out  1  read strobe to memory; high only in FETCH.
mem_rdata  in  16  memory read data, valid the cycle after mem_rd_en.
instr  out  16  held instruction word for the decoder.
instr_pc  out  ADDR_WIDTH  address of the held instruction.
instr_pc_plus1  out  ADDR_WIDTH  instr_pc+1, mod 2^ADDR_WIDTH; used as the JAL link value.
instr_valid  out  1  instr, instr_pc and instr_pc_plus1 are valid.
instr_ready  in  1  decoder consumes the held instruction this cycle.
redirect_valid  in  1  load a new PC and flush.
redirect_pc  in  ADDR_WIDTH  target PC for the redirect.

Behaviour:
- Clocking: clk and reset are fixed. Reset is synchronous and active-high and takes priority over all other inputs.
- States: IDLE, FETCH, WAIT, HOLD.
- Reset values: state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_pc_plus1=0, instr_valid=0, mem_rd_en=0.
- IDLE: goes to FETCH unconditionally on the next clock. It exists so that mem_rd_en is 0 during reset and in the first cycle after it.
- FETCH: mem_rd_en=1, mem_addr=pc. Goes to WAIT.
- WAIT: mem_rdata is valid this cycle. At the clock edge:
  - instr<=mem_rdata, instr_pc<=pc, instr_pc_plus1<=pc+1;
  - pc<=pc+1;
  - instr_valid<=1;
  - state goes to HOLD.
- HOLD: instr_valid=1. Outputs stay stable while instr_ready=0.
  - instr_ready=1: instr_valid<=0 and state goes to FETCH.
  - The handshake completes only when valid and ready are both high in the same cycle.
- Throughput: one instruction per 3 cycles when instr_ready is tied high.
- First-fetch latency: reset deasserts at the edge ending cycle 0 (IDLE). Cycle 1 is FETCH at RESET_PC, cycle 2 is WAIT, and instr_valid=1 from cycle 3.
- mem_addr = pc in every state. Memory ignores it when mem_rd_en=0.
- Redirect: redirect_valid=1 in IDLE, FETCH, WAIT or HOLD causes, at the next edge:
  - pc<=redirect_pc and instr_valid<=0, state goes to FETCH;
  - any in-flight read is discarded (WAIT data is not captured);
  - a held instruction is dropped even if instr_ready=1 the same cycle.
- Simultaneous events:
  - reset and redirect_valid: reset wins.
  - redirect_valid and handshake in HOLD: redirect wins, and the decoder must treat the instruction as squashed.
- Wrap-around: pc=2^ADDR_WIDTH-1 increments to 0. instr_pc_plus1 wraps identically. No overflow flag.
- Reset mid-operation: returns to IDLE from any state and drops valid. Read data arriving the next cycle is ignored.
- The block does not decode the instruction. Decode and the sign-extension of immediates belong to the decode stage.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE=2'd0, FETCH=2'd1, WAIT=2'd2, HOLD=2'd3);
  - INSTR_WIDTH=16;
  - the default RESET_PC.
- The same package also serves the decode stage's opcode constants.
- No sub-module. The PC register and FSM fit in a single module.

Test Plan:
- Reset release, memory[0]=16'h5103, instr_ready=1 → mem_rd_en=1 with mem_addr=0 in cycle 1; instr_valid=1, instr=16'h5103, instr_pc=0, instr_pc_plus1=1 in cycle 3; mem_addr=1 in cycle 4.
- Backpressure: instr_ready=0 for 5 cycles in HOLD → instr and instr_pc stable, mem_rd_en=0 throughout; ready=1 → next FETCH at pc+1.
- Redirect in WAIT to 16'h0040 → held instr does not change and instr_valid stays 0; next FETCH at mem_addr=16'h0040; delivered instr_pc=16'h0040.
- Redirect in HOLD with instr_ready=1 the same cycle → instr_valid=0 next cycle; fetch at redirect_pc; no instruction from pc+1 delivered.
- Wrap: redirect_pc=16'hFFFF, memory[FFFF]=16'h0000 → instr_pc=16'hFFFF, instr_pc_plus1=16'h0000, next mem_addr=16'h0000.
- reset asserted in WAIT together with redirect_valid → next cycle state IDLE, instr_valid=0, pc=RESET_PC; first fetch after release at RESET_PC.
